// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, default NOP encoding, fetch FSM states.
// Also holds the sequential-PC helper used by the fetch stage.
package cpu_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0
    localparam logic [XLEN-1:0] NOP_INSN_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_RESP = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_hold_buffer.sv
// One-entry parking slot for a fetched word that arrived while downstream stalled.
// Load sets full; drain or clear empties it; clear wins over load.
module if_hold_buffer
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_drain,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_insn,
    input  logic [XLEN-1:0] i_pc,
    output logic [XLEN-1:0] o_insn,
    output logic [XLEN-1:0] o_pc,
    output logic            o_full
);

    logic [XLEN-1:0] r_insn;
    logic [XLEN-1:0] r_pc;
    logic            r_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_insn <= '0;
            r_pc   <= '0;
            r_full <= 1'b0;
        end else if (i_clear) begin
            r_insn <= '0;
            r_pc   <= '0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_insn <= i_insn;
            r_pc   <= i_pc;
            r_full <= 1'b1;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_insn = r_insn;
    assign o_pc   = r_pc;
    assign o_full = r_full;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, one outstanding imem request, loads IF/ID outputs.
// Optional perf counters (perf_fetched, perf_stall_cycles) under `define IF_PERF_CNT_EN.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSN = NOP_INSN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instruction_out,
    output logic [XLEN-1:0] pc_out,
    output logic            valid_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall_cycles
`endif
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] w_req_pc_nxt;
    logic            r_kill;
    logic            w_kill_nxt;

    logic [XLEN-1:0] r_insn_out;
    logic [XLEN-1:0] r_pc_out;
    logic            r_valid_out;

    logic            w_load;
    logic [XLEN-1:0] w_ld_insn;
    logic [XLEN-1:0] w_ld_pc;
    logic            w_hold_load;
    logic            w_hold_drain;
    logic            w_hold_clear;
    logic [XLEN-1:0] w_hold_insn;
    logic [XLEN-1:0] w_hold_pc;
    logic            w_hold_full;
    logic [XLEN-1:0] w_redirect_pc_al;

    assign w_redirect_pc_al = redirect_pc & ~32'd3;

    if_hold_buffer u_hold (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_hold_load),
        .i_drain (w_hold_drain),
        .i_clear (w_hold_clear),
        .i_insn  (imem_rdata),
        .i_pc    (r_req_pc),
        .o_insn  (w_hold_insn),
        .o_pc    (w_hold_pc),
        .o_full  (w_hold_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_REQ;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
            r_kill   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_req_pc <= w_req_pc_nxt;
            r_kill   <= w_kill_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_req_pc_nxt = r_req_pc;
        w_kill_nxt   = r_kill;
        w_load       = 1'b0;
        w_ld_insn    = imem_rdata;
        w_ld_pc      = r_req_pc;
        w_hold_load  = 1'b0;
        w_hold_drain = 1'b0;
        w_hold_clear = 1'b0;

        case (r_state)
            ST_REQ: begin
                if (imem_gnt) begin
                    w_state_nxt  = ST_RESP;
                    w_req_pc_nxt = r_pc;
                    // A grant racing a redirect still owes us a response; poison it.
                    if (redirect) begin
                        w_kill_nxt = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (imem_rvalid) begin
                    w_state_nxt = ST_REQ;
                    w_kill_nxt  = 1'b0;
                    if (!r_kill && !redirect) begin
                        if (stall) begin
                            w_hold_load = 1'b1;
                            w_state_nxt = ST_HOLD;
                        end else begin
                            w_load   = 1'b1;
                            w_pc_nxt = seq_pc(r_req_pc);
                        end
                    end
                end else if (redirect) begin
                    w_kill_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    w_hold_clear = 1'b1;
                    w_state_nxt  = ST_REQ;
                end else if (!stall && w_hold_full) begin
                    w_hold_drain = 1'b1;
                    w_load       = 1'b1;
                    w_ld_insn    = w_hold_insn;
                    w_ld_pc      = w_hold_pc;
                    w_pc_nxt     = seq_pc(w_hold_pc);
                    w_state_nxt  = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_REQ;
            end
        endcase

        if (redirect) begin
            w_pc_nxt = w_redirect_pc_al;
            w_load   = 1'b0;
        end
    end

    // Redirect squashes, a load fills, stall freezes, otherwise a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_insn_out  <= NOP_INSN;
            r_pc_out    <= '0;
            r_valid_out <= 1'b0;
        end else if (redirect) begin
            r_insn_out  <= NOP_INSN;
            r_valid_out <= 1'b0;
        end else if (w_load) begin
            r_insn_out  <= w_ld_insn;
            r_pc_out    <= w_ld_pc;
            r_valid_out <= 1'b1;
        end else if (!stall) begin
            r_insn_out  <= NOP_INSN;
            r_valid_out <= 1'b0;
        end
    end

    assign imem_req        = (r_state == ST_REQ);
    assign imem_addr       = r_pc;
    assign instruction_out = r_insn_out;
    assign pc_out          = r_pc_out;
    assign valid_out       = r_valid_out;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetched      <= '0;
            r_perf_stall_cycles <= '0;
        end else begin
            if (w_load) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (stall && r_valid_out) begin
                r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
            end
        end
    end

    assign perf_fetched      = r_perf_fetched;
    assign perf_stall_cycles = r_perf_stall_cycles;
`endif

endmodule
